// File: rtl/ws281x_pkg.sv
// Shared types and defaults for the WS281x serial transmitter.
// Optional feature macro: WS281X_UNDERRUN_FLAG_EN (adds underrun_o on ws281x_tx).
package ws281x_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 24;
   localparam int unsigned CNT_WIDTH_DEF  = 8;
   localparam int unsigned RST_WIDTH_DEF  = 16;

   // Shortest usable bit period; anything below is clamped up to this.
   localparam int unsigned P_MIN = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BIT   = 2'd1,
      LATCH = 2'd2
   } state_t;

   // Index width that stays legal for a one-bit word.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws281x_bit_timer.sv
// Bit-period counter for one NRZ bit: level is high while the count is below
// the high time, bit_end marks the last cycle of the period.
module ws281x_bit_timer
   import ws281x_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 run,
   input  logic [CNT_WIDTH-1:0] period,
   input  logic [CNT_WIDTH-1:0] high,
   output logic                 level,
   output logic                 bit_end
);

   logic [CNT_WIDTH-1:0] cnt;

   assign level   = (cnt < high);
   assign bit_end = (cnt == (period - CNT_WIDTH'(1)));

   // A fresh pixel always restarts the period from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= bit_end ? '0 : (cnt + CNT_WIDTH'(1));
      end
   end

endmodule

// File: rtl/ws281x_tx.sv
// WS281x NRZ transmitter: accepts pixel words over valid/ready, shifts them out
// MSB-first and appends a latch gap. Optional macro: WS281X_UNDERRUN_FLAG_EN.
module ws281x_tx
   import ws281x_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
   parameter int unsigned RST_WIDTH  = RST_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CNT_WIDTH-1:0]  t0h_cnt_i,
   input  logic [CNT_WIDTH-1:0]  t1h_cnt_i,
   input  logic [CNT_WIDTH-1:0]  bit_cnt_i,
   input  logic [RST_WIDTH-1:0]  rst_cnt_i,
   input  logic                  pix_vld_i,
   input  logic [DATA_WIDTH-1:0] pix_data_i,
   input  logic                  pix_last_i,
   output logic                  pix_rdy_o,
   output logic                  ws_dout_o,
   output logic                  busy_o,
   output logic                  frame_done_o
`ifdef WS281X_UNDERRUN_FLAG_EN
   ,
   output logic                  underrun_o
`endif
);

   localparam int unsigned          IDX_W    = idx_width(DATA_WIDTH);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] P_FLOOR  = CNT_WIDTH'(P_MIN);

   state_t                state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [IDX_W-1:0]      bit_idx;
   logic [RST_WIDTH-1:0]  lat_cnt;
   logic                  last_q;
   logic [CNT_WIDTH-1:0]  t0h_q;
   logic [CNT_WIDTH-1:0]  t1h_q;
   logic [CNT_WIDTH-1:0]  bit_q;
   logic [RST_WIDTH-1:0]  rst_q;

   logic [CNT_WIDTH-1:0]  period;
   logic [CNT_WIDTH-1:0]  high;
   logic                  level;
   logic                  bit_end;
   logic                  final_bit;
   logic                  accept;
   logic                  underrun;
   logic                  gap_end;

   // Timing comes only from the shadow copies taken at acceptance.
   assign period = (bit_q < P_FLOOR) ? P_FLOOR : bit_q;
   assign high   = shreg[DATA_WIDTH-1] ? t1h_q : t0h_q;

   assign final_bit = (state == BIT) && bit_end && (bit_idx == LAST_IDX);
   assign pix_rdy_o = !rst_i && ((state == IDLE) || (final_bit && !last_q));
   assign accept    = pix_vld_i && pix_rdy_o;
   assign underrun  = final_bit && !last_q && !accept;
   assign gap_end   = (rst_q == '0) || (lat_cnt == (rst_q - RST_WIDTH'(1)));

   ws281x_bit_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_bit_timer (
      .clk     (clk_i),
      .rst     (rst_i),
      .start   (accept),
      .run     (state == BIT),
      .period  (period),
      .high    (high),
      .level   (level),
      .bit_end (bit_end)
   );

   // Control FSM; the line is the timer level delayed by one register stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         shreg        <= '0;
         bit_idx      <= '0;
         lat_cnt      <= '0;
         last_q       <= 1'b0;
         t0h_q        <= '0;
         t1h_q        <= '0;
         bit_q        <= '0;
         rst_q        <= '0;
         ws_dout_o    <= 1'b0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         ws_dout_o    <= (state == BIT) && level;

         if (accept) begin
            shreg   <= pix_data_i;
            last_q  <= pix_last_i;
            t0h_q   <= t0h_cnt_i;
            t1h_q   <= t1h_cnt_i;
            bit_q   <= bit_cnt_i;
            rst_q   <= rst_cnt_i;
            bit_idx <= '0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  state  <= BIT;
                  busy_o <= 1'b1;
               end
            end
            BIT: begin
               if (bit_end) begin
                  if (bit_idx != LAST_IDX) begin
                     shreg   <= shreg << 1;
                     bit_idx <= bit_idx + IDX_W'(1);
                  end else if (accept) begin
                     state <= BIT;
                  end else if (last_q) begin
                     state   <= LATCH;
                     lat_cnt <= '0;
                  end else begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end
               end
            end
            LATCH: begin
               if (gap_end) begin
                  state        <= IDLE;
                  busy_o       <= 1'b0;
                  frame_done_o <= 1'b1;
               end else begin
                  lat_cnt <= lat_cnt + RST_WIDTH'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef WS281X_UNDERRUN_FLAG_EN
   // Sticky until the next frame-closing pixel is taken.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         underrun_o <= 1'b0;
      end else if (accept && pix_last_i) begin
         underrun_o <= 1'b0;
      end else if (underrun) begin
         underrun_o <= 1'b1;
      end
   end
`else
   logic unused_underrun;
   assign unused_underrun = underrun;
`endif

endmodule
